// File: rtl/tetris_pkg.sv
// Shared encodings, default geometry and lock-cell packing helper for the Tetris board engine.
package tetris_pkg;

  localparam int unsigned DEF_COLS  = 10;
  localparam int unsigned DEF_ROWS  = 12;
  localparam int unsigned DEF_ROW_W = 4;
  localparam int unsigned DEF_COL_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACTIVE = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_LOST   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StActive = ST_ACTIVE,
    StClear  = ST_CLEAR,
    StFill   = ST_FILL,
    StLost   = ST_LOST
  } state_e;

  // Cell idx of a lock occupies bits [idx*width +: width] of lock_rows / lock_cols.
  function automatic int unsigned cell_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/tetris_score_acc.sv
// Saturating score (PTS_LINE*n*n per pass) and cleared-line total accumulator.
module tetris_score_acc
  import tetris_pkg::*;
#(
  parameter int unsigned SCORE_W  = 16,
  parameter int unsigned PTS_LINE = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic [2:0]         n_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] total_o
);

  // Headroom so PTS_LINE*n*n plus the old score never wraps before the clamp.
  localparam int unsigned WideW = SCORE_W + 16;
  localparam int unsigned TotW  = SCORE_W + 1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] total_q, total_d;
  logic [WideW-1:0]   inc;
  logic [WideW-1:0]   sum;
  logic [TotW-1:0]    tsum;

  always_comb begin
    inc     = WideW'(PTS_LINE) * WideW'(n_i) * WideW'(n_i);
    sum     = WideW'(score_q) + inc;
    tsum    = {1'b0, total_q} + TotW'(n_i);
    score_d = score_q;
    total_d = total_q;
    if (clr_i) begin
      score_d = '0;
      total_d = '0;
    end else if (add_i) begin
      score_d = (|sum[WideW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
      total_d = tsum[SCORE_W] ? '1 : tsum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      score_q <= '0;
      total_q <= '0;
    end else begin
      score_q <= score_d;
      total_q <= total_d;
    end
  end

  assign score_o = score_q;
  assign total_o = total_q;

endmodule

// File: rtl/tetris_board_engine.sv
// Playfield bitmap with 4-cell lock port, bottom-up line compaction and read ports.
module tetris_board_engine
  import tetris_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned ROW_W    = DEF_ROW_W,
  parameter int unsigned COL_W    = DEF_COL_W,
  parameter int unsigned TOP_ROWS = 1,
  parameter int unsigned PTS_LINE = 10,
  parameter int unsigned SCORE_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic               lock_valid,
  output logic               lock_ready,
  input  logic [4*ROW_W-1:0] lock_rows,
  input  logic [4*COL_W-1:0] lock_cols,
  input  logic [ROW_W-1:0]   probe_row,
  input  logic [COL_W-1:0]   probe_col,
  output logic               probe_hit,
  input  logic [ROW_W-1:0]   disp_row,
  output logic [COLS-1:0]    disp_data,
  output logic               gen_flag,
  output logic               q_idle,
  output logic               q_active,
  output logic               q_clear,
  output logic               q_lost,
  output logic [2:0]         lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] total_lines
);

  state_e           state_q, state_d;
  logic [COLS-1:0]  board_q [ROWS];
  logic [COLS-1:0]  board_d [ROWS];
  logic [ROW_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0]       n_q, n_d, fill_q, fill_d, lines_q, lines_d;
  logic             gen_q, gen_d;
  logic             commit, clr;

  logic [3:0][ROW_W-1:0] cell_row;
  logic [3:0][COL_W-1:0] cell_col;
  logic [3:0]            cell_ok, cell_top;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    assign cell_row[g] = lock_rows[cell_lsb(g, ROW_W) +: ROW_W];
    assign cell_col[g] = lock_cols[cell_lsb(g, COL_W) +: COL_W];
    assign cell_ok[g]  = (32'(cell_row[g]) < ROWS) && (32'(cell_col[g]) < COLS);
    assign cell_top[g] = cell_ok[g] && (32'(cell_row[g]) < TOP_ROWS);
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    n_d     = n_q;
    fill_d  = fill_q;
    lines_d = lines_q;
    gen_d   = 1'b0;
    commit  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        clr = 1'b1;
        for (int i = 0; i < ROWS; i++) board_d[i] = '0;
        if (Start) begin
          state_d = StActive;
          gen_d   = 1'b1;
        end
      end
      StActive: begin
        if (lock_valid) begin
          for (int i = 0; i < 4; i++) begin
            if (cell_ok[i]) board_d[cell_row[i]][cell_col[i]] = 1'b1;
          end
          state_d = (|cell_top) ? StLost : StClear;
          rd_d    = ROW_W'(ROWS - 1);
          wr_d    = ROW_W'(ROWS - 1);
          n_d     = '0;
        end
      end
      StClear: begin
        // wr never drops below rd, so copying down in place is safe.
        if (&board_q[rd_q]) begin
          n_d = (n_q == 3'd7) ? n_q : n_q + 3'd1;
        end else begin
          board_d[wr_q] = board_q[rd_q];
          wr_d          = wr_q - 1'b1;
        end
        rd_d = rd_q - 1'b1;
        if (rd_q == '0) begin
          if (n_d == '0) begin
            state_d = StActive;
            commit  = 1'b1;
          end else begin
            state_d = StFill;
            fill_d  = n_d;
          end
        end
      end
      StFill: begin
        board_d[wr_q] = '0;
        wr_d          = wr_q - 1'b1;
        fill_d        = fill_q - 3'd1;
        if (fill_q == 3'd1) begin
          state_d = StActive;
          commit  = 1'b1;
        end
      end
      StLost: begin
        if (Ack) begin
          state_d = StIdle;
          clr     = 1'b1;
          for (int i = 0; i < ROWS; i++) board_d[i] = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      lines_d = n_d;
      gen_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      for (int i = 0; i < ROWS; i++) board_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      n_q     <= '0;
      fill_q  <= '0;
      lines_q <= '0;
      gen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      n_q     <= n_d;
      fill_q  <= fill_d;
      lines_q <= lines_d;
      gen_q   <= gen_d;
    end
  end

  tetris_score_acc #(
    .SCORE_W  (SCORE_W),
    .PTS_LINE (PTS_LINE)
  ) u_score_acc (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (clr),
    .add_i   (commit),
    .n_i     (n_d),
    .score_o (score),
    .total_o (total_lines)
  );

  assign lock_ready    = (state_q == StActive);
  assign q_idle        = (state_q == StIdle);
  assign q_active      = (state_q == StActive);
  assign q_clear       = (state_q == StClear) || (state_q == StFill);
  assign q_lost        = (state_q == StLost);
  assign gen_flag      = gen_q;
  assign lines_cleared = lines_q;

  assign probe_hit = ((32'(probe_row) >= ROWS) || (32'(probe_col) >= COLS)) ? 1'b1 :
                     board_q[probe_row][probe_col];
  assign disp_data = (32'(disp_row) < ROWS) ? board_q[disp_row] : '0;

endmodule

// File: tb/tb_tetris_board_engine.sv
// Directed bench for tetris_board_engine: lock vector table plus loss and reset sequences.
module tb_tetris_board_engine;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack, lock_valid, lock_ready;
  logic [15:0] lock_rows, lock_cols;
  logic [3:0]  probe_row, probe_col, disp_row;
  logic        probe_hit, gen_flag, q_idle, q_active, q_clear, q_lost;
  logic [9:0]  disp_data;
  logic [2:0]  lines_cleared;
  logic [15:0] score, total_lines;

  int checks = 0;
  int failures = 0;

  always #50 Clk = ~Clk;

  tetris_board_engine u_dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .Ack           (Ack),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_rows     (lock_rows),
    .lock_cols     (lock_cols),
    .probe_row     (probe_row),
    .probe_col     (probe_col),
    .probe_hit     (probe_hit),
    .disp_row      (disp_row),
    .disp_data     (disp_data),
    .gen_flag      (gen_flag),
    .q_idle        (q_idle),
    .q_active      (q_active),
    .q_clear       (q_clear),
    .q_lost        (q_lost),
    .lines_cleared (lines_cleared),
    .score         (score),
    .total_lines   (total_lines)
  );

  typedef struct {
    logic [15:0] rows;
    logic [15:0] cols;
    int          lat;
    int          lines;
    int          score;
    int          total;
    logic [9:0]  r8, r9, r10, r11;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_row(input int r, output logic [9:0] v);
    disp_row = 4'(r);
    #1;
    v = disp_data;
  endtask

  task automatic probe(input int r, input int c, output logic v);
    probe_row = 4'(r);
    probe_col = 4'(c);
    #1;
    v = probe_hit;
  endtask

  task automatic chk_rows_zero(input int lo, input int hi, input string name);
    logic [9:0] acc, v;
    acc = '0;
    for (int r = lo; r <= hi; r++) begin
      read_row(r, v);
      acc = acc | v;
    end
    chk(name, 32'(acc), 32'h0);
  endtask

  task automatic accept_lock(input logic [15:0] r, input logic [15:0] c);
    int t = 0;
    while (!lock_ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    chk("lock_ready_wait", 32'(lock_ready), 32'h1);
    lock_rows  = r;
    lock_cols  = c;
    lock_valid = 1'b1;
    @(negedge Clk);
    lock_valid = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after acceptance) where gen_flag is seen.
  task automatic wait_gen(output int k);
    k = 1;
    while (!gen_flag && k < 60) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic start_game();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("start_gen_flag", 32'(gen_flag), 32'h1);
    chk("start_q_active", 32'(q_active), 32'h1);
    @(negedge Clk);
    chk("start_gen_pulse", 32'(gen_flag), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] rv;
    logic       ph;
    int         k;

    vecs[0]  = '{pk(11, 11, 11, 11), pk(0, 1, 2, 3), 13, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h00F};
    vecs[1]  = '{pk(11, 11, 11, 11), pk(4, 5, 6, 7), 13, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h0FF};
    vecs[2]  = '{pk(11, 10, 10, 10), pk(8, 0, 1, 2), 13, 0, 0, 0, 10'h000, 10'h000, 10'h007, 10'h1FF};
    vecs[3]  = '{pk(10, 10, 10, 10), pk(3, 4, 5, 6), 13, 0, 0, 0, 10'h000, 10'h000, 10'h07F, 10'h1FF};
    vecs[4]  = '{pk(10, 10, 15, 0), pk(7, 8, 0, 12), 13, 0, 0, 0, 10'h000, 10'h000, 10'h1FF, 10'h1FF};
    vecs[5]  = '{pk(11, 10, 9, 8), pk(9, 9, 9, 9), 15, 2, 40, 2, 10'h000, 10'h000, 10'h200, 10'h200};
    vecs[6]  = '{pk(11, 11, 11, 11), pk(1, 2, 3, 4), 13, 0, 40, 2, 10'h000, 10'h000, 10'h200, 10'h21E};
    vecs[7]  = '{pk(11, 11, 11, 11), pk(5, 6, 7, 8), 13, 0, 40, 2, 10'h000, 10'h000, 10'h200, 10'h3FE};
    vecs[8]  = '{pk(10, 10, 10, 10), pk(1, 2, 3, 4), 13, 0, 40, 2, 10'h000, 10'h000, 10'h21E, 10'h3FE};
    vecs[9]  = '{pk(10, 10, 10, 10), pk(5, 6, 7, 8), 13, 0, 40, 2, 10'h000, 10'h000, 10'h3FE, 10'h3FE};
    vecs[10] = '{pk(9, 9, 9, 9), pk(1, 2, 3, 4), 13, 0, 40, 2, 10'h000, 10'h01E, 10'h3FE, 10'h3FE};
    vecs[11] = '{pk(9, 9, 9, 9), pk(5, 6, 7, 8), 13, 0, 40, 2, 10'h000, 10'h1FE, 10'h3FE, 10'h3FE};
    vecs[12] = '{pk(9, 8, 8, 8), pk(9, 1, 2, 3), 13, 0, 40, 2, 10'h00E, 10'h3FE, 10'h3FE, 10'h3FE};
    vecs[13] = '{pk(8, 8, 8, 8), pk(4, 5, 6, 7), 13, 0, 40, 2, 10'h0FE, 10'h3FE, 10'h3FE, 10'h3FE};
    vecs[14] = '{pk(8, 8, 8, 8), pk(8, 9, 9, 9), 13, 0, 40, 2, 10'h3FE, 10'h3FE, 10'h3FE, 10'h3FE};
    vecs[15] = '{pk(8, 9, 10, 11), pk(0, 0, 0, 0), 17, 4, 200, 6, 10'h000, 10'h000, 10'h000, 10'h000};

    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; lock_valid = 1'b0;
    lock_rows = '0; lock_cols = '0; probe_row = '0; probe_col = '0; disp_row = '0;
    repeat (2) @(negedge Clk);
    chk("rst_q_idle", 32'(q_idle), 32'h1);
    chk("rst_lock_ready", 32'(lock_ready), 32'h0);
    chk("rst_gen_flag", 32'(gen_flag), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_total", 32'(total_lines), 32'h0);
    chk("rst_lines", 32'(lines_cleared), 32'h0);
    chk_rows_zero(0, 11, "rst_board");
    probe(0, 0, ph);
    chk("rst_probe_00", 32'(ph), 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    start_game();
    for (int i = 0; i < 16; i++) begin
      accept_lock(vecs[i].rows, vecs[i].cols);
      wait_gen(k);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(vecs[i].lat));
      chk($sformatf("v%0d_lines", i), 32'(lines_cleared), 32'(vecs[i].lines));
      chk($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].score));
      chk($sformatf("v%0d_total", i), 32'(total_lines), 32'(vecs[i].total));
      read_row(8, rv);  chk($sformatf("v%0d_row8", i), 32'(rv), 32'(vecs[i].r8));
      read_row(9, rv);  chk($sformatf("v%0d_row9", i), 32'(rv), 32'(vecs[i].r9));
      read_row(10, rv); chk($sformatf("v%0d_row10", i), 32'(rv), 32'(vecs[i].r10));
      read_row(11, rv); chk($sformatf("v%0d_row11", i), 32'(rv), 32'(vecs[i].r11));
      chk_rows_zero(0, 7, $sformatf("v%0d_rows0_7", i));
      @(negedge Clk);
      chk($sformatf("v%0d_gen_pulse", i), 32'(gen_flag), 32'h0);
      chk($sformatf("v%0d_q_active", i), 32'(q_active), 32'h1);
    end

    // Loss zone lock, then ignored locks/Start, then Ack.
    accept_lock(pk(0, 1, 2, 3), pk(0, 0, 0, 0));
    chk("lost_q_lost", 32'(q_lost), 32'h1);
    chk("lost_lock_ready", 32'(lock_ready), 32'h0);
    read_row(0, rv);  chk("lost_row0", 32'(rv), 32'h001);
    read_row(3, rv);  chk("lost_row3", 32'(rv), 32'h001);
    read_row(12, rv); chk("disp_row12", 32'(rv), 32'h0);
    probe(0, 0, ph);  chk("probe_0_0", 32'(ph), 32'h1);
    probe(5, 12, ph); chk("probe_5_12", 32'(ph), 32'h1);
    probe(12, 3, ph); chk("probe_12_3", 32'(ph), 32'h1);
    probe(11, 0, ph); chk("probe_11_0", 32'(ph), 32'h0);
    lock_rows = pk(11, 11, 11, 11);
    lock_cols = pk(0, 1, 2, 3);
    lock_valid = 1'b1;
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    lock_valid = 1'b0;
    Start = 1'b0;
    chk("lost_hold", 32'(q_lost), 32'h1);
    read_row(11, rv); chk("lost_row11", 32'(rv), 32'h0);
    chk("lost_score", 32'(score), 32'd200);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    chk("ack_q_idle", 32'(q_idle), 32'h1);
    chk_rows_zero(0, 11, "ack_board");
    chk("ack_score", 32'(score), 32'h0);
    chk("ack_total", 32'(total_lines), 32'h0);

    // Second game: reach the first FILL cycle with 2 rows pending, then reset.
    start_game();
    for (int i = 0; i < 5; i++) begin
      accept_lock(vecs[i].rows, vecs[i].cols);
      wait_gen(k);
    end
    accept_lock(vecs[5].rows, vecs[5].cols);
    repeat (12) @(negedge Clk);
    chk("fill_q_clear", 32'(q_clear), 32'h1);
    chk("fill_gen_flag", 32'(gen_flag), 32'h0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midfill_q_idle", 32'(q_idle), 32'h1);
    chk("midfill_q_clear", 32'(q_clear), 32'h0);
    chk_rows_zero(0, 11, "midfill_board");
    chk("midfill_score", 32'(score), 32'h0);
    chk("midfill_total", 32'(total_lines), 32'h0);
    chk("midfill_gen", 32'(gen_flag), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
